// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: sequencer states, default widths,
// the halt opcode and the control-word bit positions the sequencer interprets.
package cpu_pkg;

    localparam int WIDTH_OPCODE_DEF         = 4;
    localparam int WIDTH_CONTROL_SIGNAL_DEF = 10;
    localparam int WIDTH_PC_DEF             = 8;
    localparam int WIDTH_INSTR_DEF          = 16;
    localparam int ACK_TIMEOUT_DEF          = 16;

    localparam logic [3:0] OPC_HALT = 4'd15;

    localparam int MEM_RD_BIT = 9;
    localparam int REG_WR_BIT = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    function automatic logic is_busy(input state_t s);
        return !(s == IDLE || s == HALT);
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Counts consecutive cycles spent waiting for an acknowledge; expired flags the
// last allowed waiting cycle so the caller can give up at that edge.
module ack_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Ack in the final cycle wins because enable is already low when ack is present.
    assign expired = enable && (count_q == CW'(LIMIT - 1));

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer; the control decoder sits outside and
// is driven by Opcode, its word sampled back through ControlSignal.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH_OPCODE         = WIDTH_OPCODE_DEF,
    parameter int WIDTH_CONTROL_SIGNAL = WIDTH_CONTROL_SIGNAL_DEF,
    parameter int WIDTH_PC             = WIDTH_PC_DEF,
    parameter int WIDTH_INSTR          = WIDTH_INSTR_DEF,
    parameter int ACK_TIMEOUT          = ACK_TIMEOUT_DEF
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            Start,
    output logic                            InstrReq,
    output logic [WIDTH_PC-1:0]             InstrAddr,
    input  logic                            InstrAck,
    input  logic [WIDTH_INSTR-1:0]          InstrData,
    output logic [WIDTH_OPCODE-1:0]         Opcode,
    input  logic [WIDTH_CONTROL_SIGNAL-1:0] ControlSignal,
    output logic [WIDTH_INSTR-1:0]          Ir,
    output logic [WIDTH_CONTROL_SIGNAL-1:0] CtrlReg,
    output logic                            MemReq,
    input  logic                            MemAck,
    output logic                            RegWrite,
    output logic                            Busy,
    output logic                            Halted,
    output logic                            Error
);

    state_t                            state_q, state_d;
    logic [WIDTH_PC-1:0]               pc_q, pc_d;
    logic [WIDTH_INSTR-1:0]            ir_q, ir_d;
    logic [WIDTH_CONTROL_SIGNAL-1:0]   ctrl_q, ctrl_d;
    logic                              error_q, error_d;
    logic                              instr_req_q, instr_req_d;
    logic                              mem_req_q, mem_req_d;
    logic                              reg_write_q, reg_write_d;
    logic                              busy_q, busy_d;
    logic                              halted_q, halted_d;

    logic waiting;
    logic timer_enable;
    logic timer_expired;

    assign waiting      = (state_q == FETCH) || (state_q == MEM);
    assign timer_enable = ((state_q == FETCH) && !InstrAck) || ((state_q == MEM) && !MemAck);

    // Held clear in every non-waiting state, so it starts from zero on entry to FETCH or MEM.
    ack_timer #(
        .LIMIT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .clear  (!waiting),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ctrl_d  = ctrl_q;
        error_d = error_q;

        case (state_q)
            IDLE: begin
                if (Start) state_d = FETCH;
            end
            FETCH: begin
                if (InstrAck) begin
                    ir_d    = InstrData;
                    state_d = DECODE;
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = HALT;
                end
            end
            DECODE: begin
                ctrl_d = ControlSignal;
                if (Opcode == WIDTH_OPCODE'(OPC_HALT)) begin
                    state_d = HALT;
                end else if (ControlSignal[MEM_RD_BIT]) begin
                    state_d = MEM;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            MEM: begin
                if (MemAck) begin
                    state_d = WB;
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = HALT;
                end
            end
            WB: begin
                pc_d    = pc_q + WIDTH_PC'(1);
                state_d = FETCH;
            end
            HALT: begin
                if (Start) begin
                    pc_d    = '0;
                    error_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state, so they follow state_q exactly.
        instr_req_d = (state_d == FETCH);
        mem_req_d   = (state_d == MEM);
        reg_write_d = (state_d == WB) && ctrl_d[REG_WR_BIT];
        busy_d      = is_busy(state_d);
        halted_d    = (state_d == HALT);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            ctrl_q      <= '0;
            error_q     <= 1'b0;
            instr_req_q <= 1'b0;
            mem_req_q   <= 1'b0;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ctrl_q      <= ctrl_d;
            error_q     <= error_d;
            instr_req_q <= instr_req_d;
            mem_req_q   <= mem_req_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign InstrReq  = instr_req_q;
    assign InstrAddr = pc_q;
    assign Opcode    = ir_q[WIDTH_INSTR-1 -: WIDTH_OPCODE];
    assign Ir        = ir_q;
    assign CtrlReg   = ctrl_q;
    assign MemReq    = mem_req_q;
    assign RegWrite  = reg_write_q;
    assign Busy      = busy_q;
    assign Halted    = halted_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small stand-in control decoder;
// all expected values are hand-derived constants.
module tb_instr_sequencer;
    import cpu_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        InstrReq;
    logic [7:0]  InstrAddr;
    logic        InstrAck;
    logic [15:0] InstrData;
    logic [3:0]  Opcode;
    logic [9:0]  ControlSignal;
    logic [15:0] Ir;
    logic [9:0]  CtrlReg;
    logic        MemReq;
    logic        MemAck;
    logic        RegWrite;
    logic        Busy;
    logic        Halted;
    logic        Error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    instr_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .InstrReq     (InstrReq),
        .InstrAddr    (InstrAddr),
        .InstrAck     (InstrAck),
        .InstrData    (InstrData),
        .Opcode       (Opcode),
        .ControlSignal(ControlSignal),
        .Ir           (Ir),
        .CtrlReg      (CtrlReg),
        .MemReq       (MemReq),
        .MemAck       (MemAck),
        .RegWrite     (RegWrite),
        .Busy         (Busy),
        .Halted       (Halted),
        .Error        (Error)
    );

    // Stand-in decoder: 1 = load without write, 2 = load with write, 3 = ALU with write.
    always_comb begin
        ControlSignal = 10'h000;
        case (Opcode)
            4'd1:    ControlSignal = 10'h200;
            4'd2:    ControlSignal = 10'h201;
            4'd3:    ControlSignal = 10'h001;
            default: ControlSignal = 10'h000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, 32'(dut.state_q), 32'(exp));
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    // Zero-wait non-memory instruction, starting and ending in FETCH.
    task automatic run_instr(input logic [15:0] data);
        InstrData = data;
        InstrAck  = 1'b1;
        step();
        InstrAck  = 1'b0;
        step_n(3);
    endtask

    initial begin
        Reset_n   = 1'b0;
        Start     = 1'b0;
        InstrAck  = 1'b0;
        InstrData = 16'h0000;
        MemAck    = 1'b0;
        step_n(2);

        check_state("reset_state", IDLE);
        check("reset_addr", 32'(InstrAddr), 32'h0);
        check("reset_busy", 32'(Busy), 32'h0);
        check("reset_ireq", 32'(InstrReq), 32'h0);
        check("reset_error", 32'(Error), 32'h0);
        check("reset_ir", 32'(Ir), 32'h0);

        Reset_n = 1'b1;
        step();
        check_state("idle_hold", IDLE);

        // Basic ALU instruction, immediate ack
        Start = 1'b1;
        step();
        check_state("t1_fetch", FETCH);
        check("t1_ireq", 32'(InstrReq), 32'h1);
        check("t1_busy", 32'(Busy), 32'h1);
        Start     = 1'b0;
        InstrData = 16'h3000;
        InstrAck  = 1'b1;
        step();
        InstrAck = 1'b0;
        check_state("t1_decode", DECODE);
        check("t1_ir", 32'(Ir), 32'h3000);
        check("t1_opcode", 32'(Opcode), 32'h3);
        check("t1_ireq_drop", 32'(InstrReq), 32'h0);
        step();
        check_state("t1_exec", EXEC);
        check("t1_ctrlreg", 32'(CtrlReg), 32'h001);
        check("t1_rw_exec", 32'(RegWrite), 32'h0);
        step();
        check_state("t1_wb", WB);
        check("t1_rw_wb", 32'(RegWrite), 32'h1);
        check("t1_addr_wb", 32'(InstrAddr), 32'h0);
        step();
        check_state("t1_refetch", FETCH);
        check("t1_rw_off", 32'(RegWrite), 32'h0);
        check("t1_addr_next", 32'(InstrAddr), 32'h1);

        // Load with fetch and memory acks each delayed by three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_ireq_held", 32'(InstrReq), 32'h1);
        end
        InstrData = 16'h2000;
        InstrAck  = 1'b1;
        step();
        InstrAck = 1'b0;
        check_state("t2_decode", DECODE);
        step();
        check_state("t2_mem", MEM);
        check("t2_mreq", 32'(MemReq), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_mreq_held", 32'(MemReq), 32'h1);
            check("t2_rw_wait", 32'(RegWrite), 32'h0);
        end
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        check_state("t2_wb", WB);
        check("t2_rw_wb", 32'(RegWrite), 32'h1);
        check("t2_mreq_drop", 32'(MemReq), 32'h0);
        step();
        check("t2_rw_off", 32'(RegWrite), 32'h0);
        check("t2_addr", 32'(InstrAddr), 32'h2);

        // Walk the PC to 255, then check the wrap on an opcode-0 instruction
        for (int i = 0; i < 253; i++) run_instr(16'h0000);
        check("t3_addr_255", 32'(InstrAddr), 32'hff);
        begin
            logic rw_seen;
            rw_seen   = 1'b0;
            InstrData = 16'h0000;
            InstrAck  = 1'b1;
            step();
            InstrAck = 1'b0;
            rw_seen |= RegWrite;
            step();
            rw_seen |= RegWrite;
            step();
            rw_seen |= RegWrite;
            check_state("t3_wb", WB);
            step();
            rw_seen |= RegWrite;
            check("t3_rw_never", 32'(rw_seen), 32'h0);
            check("t3_addr_wrap", 32'(InstrAddr), 32'h0);
        end

        // Halt freezes the PC; Start restarts from address 0
        run_instr(16'h3000);
        InstrData = 16'hF000;
        InstrAck  = 1'b1;
        step();
        InstrAck = 1'b0;
        step();
        check_state("t4_halt", HALT);
        check("t4_halted", 32'(Halted), 32'h1);
        check("t4_busy", 32'(Busy), 32'h0);
        check("t4_addr", 32'(InstrAddr), 32'h1);
        step_n(2);
        check("t4_addr_frozen", 32'(InstrAddr), 32'h1);
        check_state("t4_halt_stay", HALT);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check_state("t4_restart", FETCH);
        check("t4_restart_addr", 32'(InstrAddr), 32'h0);
        check("t4_halted_off", 32'(Halted), 32'h0);

        // Ack on the 16th waiting cycle is still accepted
        step_n(15);
        check_state("t5_wait16", FETCH);
        InstrData = 16'h0000;
        InstrAck  = 1'b1;
        step();
        InstrAck = 1'b0;
        check_state("t5_late_ack", DECODE);
        check("t5_no_error", 32'(Error), 32'h0);
        step_n(3);
        check("t5_addr", 32'(InstrAddr), 32'h1);

        // Sixteen cycles with no ack time out into HALT with Error
        step_n(15);
        check("t5_ireq_before", 32'(InstrReq), 32'h1);
        check("t5_error_before", 32'(Error), 32'h0);
        step();
        check_state("t5_timeout", HALT);
        check("t5_error", 32'(Error), 32'h1);
        check("t5_ireq_drop", 32'(InstrReq), 32'h0);
        check("t5_halted", 32'(Halted), 32'h1);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check_state("t5_restart", FETCH);
        check("t5_error_clr", 32'(Error), 32'h0);
        check("t5_restart_addr", 32'(InstrAddr), 32'h0);

        // Reset in MEM with a coincident ack
        run_instr(16'h0000);
        InstrData = 16'h2000;
        InstrAck  = 1'b1;
        step();
        InstrAck = 1'b0;
        step();
        check_state("t6_mem", MEM);
        check("t6_mreq", 32'(MemReq), 32'h1);
        Reset_n = 1'b0;
        MemAck  = 1'b1;
        step();
        check_state("t6_idle", IDLE);
        check("t6_mreq_off", 32'(MemReq), 32'h0);
        check("t6_addr", 32'(InstrAddr), 32'h0);
        check("t6_ir", 32'(Ir), 32'h0);
        check("t6_ctrlreg", 32'(CtrlReg), 32'h0);
        check("t6_rw", 32'(RegWrite), 32'h0);
        Reset_n  = 1'b1;
        InstrAck = 1'b1;
        step();
        MemAck   = 1'b0;
        InstrAck = 1'b0;
        check_state("t6_ack_ignored", IDLE);
        check("t6_ireq_idle", 32'(InstrReq), 32'h0);
        check("t6_busy_idle", 32'(Busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
